// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: standard sizes, small-sigma rotate/shift amounts,
// the message-schedule FSM encoding and a rotate-right helper.
package sha256_pkg;

    localparam int unsigned NUM_ROUNDS = 64;
    localparam int unsigned WORD_W     = 32;

    // small sigma 0: ROTR7 ^ ROTR18 ^ SHR3
    localparam int unsigned S0_ROT_A = 7;
    localparam int unsigned S0_ROT_B = 18;
    localparam int unsigned S0_SHR   = 3;
    // small sigma 1: ROTR17 ^ ROTR19 ^ SHR10
    localparam int unsigned S1_ROT_A = 17;
    localparam int unsigned S1_ROT_B = 19;
    localparam int unsigned S1_SHR   = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x,
                                               input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

endpackage

// File: rtl/sha256_small_sigma.sv
// SHA-256 small sigma functions, purely combinational.
// Ports:
//   x_i  : 32-bit input word
//   s0_o : ROTR7(x) ^ ROTR18(x) ^ SHR3(x)
//   s1_o : ROTR17(x) ^ ROTR19(x) ^ SHR10(x)
module sha256_small_sigma
    import sha256_pkg::*;
(
    input  logic [WORD_W-1:0] x_i,
    output logic [WORD_W-1:0] s0_o,
    output logic [WORD_W-1:0] s1_o
);

    assign s0_o = rotr(x_i, S0_ROT_A) ^ rotr(x_i, S0_ROT_B) ^ (x_i >> S0_SHR);
    assign s1_o = rotr(x_i, S1_ROT_A) ^ rotr(x_i, S1_ROT_B) ^ (x_i >> S1_SHR);

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message-schedule expander. Captures one 512-bit block into a 16-word
// sliding window and streams W[0..63] with a valid/ready handshake; pulses
// load_init one cycle before the first word and done after W[63] transfers.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start, block_in     : begin a block (sampled only when idle), padded block
//   busy, load_init     : block in progress, load-H strobe for working registers
//   w_valid, w_ready    : schedule word handshake
//   w_out, round_idx    : current schedule word and its index t
//   done                : one-cycle pulse after the last word
module sha256_msg_schedule
    import sha256_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [511:0]      block_in,
    output logic              busy,
    output logic              load_init,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [WORD_W-1:0] w_out,
    output logic [5:0]        round_idx,
    output logic              done
);

    localparam logic [5:0] LAST_ROUND = 6'(NUM_ROUNDS - 1);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] win_q [16];
    logic [WORD_W-1:0] win_d [16];
    logic [5:0]        cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              load_init_q, load_init_d;
    logic              w_valid_q, w_valid_d;
    logic              done_q, done_d;

    logic [WORD_W-1:0] s0_s, s1_s, w_new_s;
    logic [WORD_W-1:0] s1_unused_s, s0_unused_s;

    // s0 is needed on w[1], s1 on w[14]; the other output of each copy is dropped
    sha256_small_sigma u_sigma_lo (
        .x_i  (win_q[1]),
        .s0_o (s0_s),
        .s1_o (s1_unused_s)
    );

    sha256_small_sigma u_sigma_hi (
        .x_i  (win_q[14]),
        .s0_o (s0_unused_s),
        .s1_o (s1_s)
    );

    // W[t+16] from the current window holding W[t..t+15]; wraps at 32 bits
    assign w_new_s = s1_s + win_q[9] + s0_s + win_q[0];

    // Next-state, window shift, round counter and next registered outputs
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    for (int i = 0; i < 16; i++) begin
                        win_d[i] = block_in[511 - 32 * i -: 32];
                    end
                    cnt_d   = 6'd0;
                    state_d = INIT;
                end else begin
                    state_d = IDLE;
                end
            end
            INIT: begin
                state_d = RUN;
            end
            RUN: begin
                if (w_ready) begin
                    for (int i = 0; i < 15; i++) begin
                        win_d[i] = win_q[i + 1];
                    end
                    win_d[15] = w_new_s;
                    cnt_d     = cnt_q + 6'd1;
                    if (cnt_q == LAST_ROUND) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // flags are decoded from the next state so they leave straight from flops
        busy_d      = (state_d != IDLE);
        load_init_d = (state_d == INIT);
        w_valid_d   = (state_d == RUN);
        done_d      = (state_d == DONE);
    end

    // State, window, counter and output flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 6'd0;
            busy_q      <= 1'b0;
            load_init_q <= 1'b0;
            w_valid_q   <= 1'b0;
            done_q      <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= {WORD_W{1'b0}};
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            load_init_q <= load_init_d;
            w_valid_q   <= w_valid_d;
            done_q      <= done_d;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

    assign busy      = busy_q;
    assign load_init = load_init_q;
    assign w_valid   = w_valid_q;
    assign done      = done_q;
    assign w_out     = win_q[0];
    assign round_idx = cnt_q;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Self-checking bench for sha256_msg_schedule: directed known-answer, stall,
// ignored-start, mid-block reset and 1000 random back-to-back blocks, all
// compared against a textbook SHA-256 schedule model.
module tb_sha256_msg_schedule;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [511:0] block_in;
    logic         busy;
    logic         load_init;
    logic         w_valid;
    logic         w_ready;
    logic [31:0]  w_out;
    logic [5:0]   round_idx;
    logic         done;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_w [64];

    sha256_msg_schedule dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .block_in  (block_in),
        .busy      (busy),
        .load_init (load_init),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_out     (w_out),
        .round_idx (round_idx),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%08h want=%08h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    // FIPS 180-4 schedule recurrence on a flat array
    task automatic model(input logic [511:0] b);
        for (int t = 0; t < 16; t++) exp_w[t] = b[511 - 32 * t -: 32];
        for (int t = 16; t < 64; t++) begin
            logic [31:0] a, c;
            a = ror(exp_w[t-15], 7) ^ ror(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3);
            c = ror(exp_w[t-2], 17) ^ ror(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10);
            exp_w[t] = c + exp_w[t-7] + a + exp_w[t-16];
        end
    endtask

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32 * i +: 32] = $urandom;
        return b;
    endfunction

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_load"}, {31'd0, load_init}, 32'd0);
        check({tag, "_valid"}, {31'd0, w_valid}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_wout"}, w_out, 32'd0);
        check({tag, "_idx"}, {26'd0, round_idx}, 32'd0);
    endtask

    // Runs one block from IDLE. stall_at/inj_at/rst_at < 0 disable that event.
    task automatic run_block(input logic [511:0] blk, input int stall_at, input int stall_len,
                             input int inj_at, input int rst_at, input bit kat);
        int cyc, idx, stalled;
        bit injected;
        model(blk);
        block_in = blk;
        start    = 1'b1;
        w_ready  = 1'b1;
        tick();
        start    = 1'b0;
        block_in = rand_block();
        cyc = 1;
        check("init_load", {31'd0, load_init}, 32'd1);
        check("init_busy", {31'd0, busy}, 32'd1);
        check("init_valid", {31'd0, w_valid}, 32'd0);
        tick();
        cyc++;
        idx = 0;
        stalled = 0;
        injected = 1'b0;
        while (idx < 64 && cyc < 400) begin
            if (idx == rst_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                check_idle_zero("rst_mid");
                for (int k = 0; k < 4; k++) begin
                    tick();
                    check("rst_nodone", {31'd0, done}, 32'd0);
                    check("rst_idle", {31'd0, busy}, 32'd0);
                end
                return;
            end
            check("valid", {31'd0, w_valid}, 32'd1);
            check("idx", {26'd0, round_idx}, idx);
            check("word", w_out, exp_w[idx]);
            check("busy_run", {31'd0, busy}, 32'd1);
            if (kat) begin
                case (idx)
                    0:  check("kat_w0",  w_out, 32'h61626380);
                    15: check("kat_w15", w_out, 32'h00000018);
                    16: check("kat_w16", w_out, 32'h61626380);
                    17: check("kat_w17", w_out, 32'h000F0000);
                    18: check("kat_w18", w_out, 32'h7DA86405);
                    19: check("kat_w19", w_out, 32'h600003C6);
                    default: ;
                endcase
            end
            if (idx == stall_at && stalled < stall_len) begin
                w_ready = 1'b0;
                stalled++;
            end else begin
                w_ready = 1'b1;
            end
            if (idx == inj_at && !injected) begin
                start    = 1'b1;
                block_in = rand_block();
                injected = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            cyc++;
            check("no_extra_load", {31'd0, load_init}, 32'd0);
            if (w_ready) idx++;
        end
        start   = 1'b0;
        w_ready = 1'b1;
        check("timeout", idx, 64);
        check("done_pulse", {31'd0, done}, 32'd1);
        check("done_busy", {31'd0, busy}, 32'd1);
        check("done_valid", {31'd0, w_valid}, 32'd0);
        check("done_cycle", cyc, 66 + ((stall_at >= 0) ? stall_len : 0));
        tick();
        check("post_done", {31'd0, done}, 32'd0);
        check("post_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [511:0] abc;
        rst      = 1'b1;
        start    = 1'b0;
        w_ready  = 1'b1;
        block_in = 512'd0;
        tick();
        tick();
        check_idle_zero("reset");

        // rst wins over a simultaneous start
        start    = 1'b1;
        block_in = rand_block();
        tick();
        start    = 1'b0;
        rst      = 1'b0;
        check_idle_zero("rst_vs_start");
        tick();
        check("rst_vs_start_stay", {31'd0, busy}, 32'd0);

        abc = 512'd0;
        abc[511:480] = 32'h61626380;
        abc[31:0]    = 32'h00000018;
        run_block(abc, -1, 0, -1, -1, 1'b1);
        run_block(512'd0, -1, 0, -1, -1, 1'b0);
        run_block(rand_block(), 20, 5, -1, -1, 1'b0);
        run_block(rand_block(), -1, 0, 30, -1, 1'b0);
        run_block(rand_block(), -1, 0, -1, 40, 1'b0);
        run_block(abc, -1, 0, -1, -1, 1'b1);

        for (int n = 0; n < 1000; n++) begin
            run_block(rand_block(), -1, 0, -1, -1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
